multi_sel_sched: RTL



---
 rtl/multi_sel_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/multi_sel_sched.sv
`default_nettype none
// ============================================================================
//  Module   : multi_sel_sched
//  Purpose  : Round-robin scheduler sharing one multi_sel datapath among four
//             requesters. One operation in flight: select, drive operand until
//             the unit grants, wait the fixed result latency, return the
//             result tagged with the requester id (or a timeout error).
//  Revision : 1.0  initial release
// ============================================================================
module multi_sel_sched #(
   parameter int LAT     = 4,   // grant cycle to unit_out-valid cycle, 1..15
   parameter int TIMEOUT = 15   // DRIVE cycles allowed without grant, 1..255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] req_d,
   output logic [3:0]  ack,
   output logic        rsp_valid,
   output logic [1:0]  rsp_id,
   output logic [10:0] rsp_data,
   output logic        rsp_err,
   output logic [7:0]  unit_d,
   input  logic        unit_grant,
   input  logic [10:0] unit_out,
   output logic        busy
);

   // Last timeout-counter value still allowed in DRIVE, and the latency
   // count at which unit_out is sampled (counter is 1 in the first WAIT cycle).
   localparam logic [7:0] C_TO_LAST  = 8'(TIMEOUT - 1);
   localparam logic [3:0] C_LAT_LAST = 4'(LAT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t       state_q;
   logic [1:0]   ptr_q;
   logic [1:0]   id_q;
   logic [7:0]   to_cnt_q;
   logic [3:0]   lat_cnt_q;
   logic [3:0]   ack_q;
   logic         rsp_valid_q;
   logic [1:0]   rsp_id_q;
   logic [10:0]  rsp_data_q;
   logic         rsp_err_q;
   logic [7:0]   unit_d_q;

   logic         w_win_vld;
   logic [1:0]   w_win_id;
   logic [1:0]   w_scan_idx;
   logic [7:0]   w_win_op;

   // Round-robin pick: first set request scanning ptr, ptr+1, ... mod 4.
   // Scanning from the farthest candidate back lets the nearest one win.
   always_comb begin
      w_win_vld  = 1'b0;
      w_win_id   = 2'd0;
      w_scan_idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         w_scan_idx = ptr_q + 2'(k);
         if (req[w_scan_idx]) begin
            w_win_vld = 1'b1;
            w_win_id  = w_scan_idx;
         end
      end
   end

   // Operand of the current winner; only consumed in the IDLE selection cycle.
   assign w_win_op = req_d[{w_win_id, 3'b000} +: 8];

   // Scheduler state machine with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= 2'd0;
         id_q        <= 2'd0;
         to_cnt_q    <= 8'd0;
         lat_cnt_q   <= 4'd0;
         ack_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 2'd0;
         rsp_data_q  <= 11'd0;
         rsp_err_q   <= 1'b0;
         unit_d_q    <= 8'd0;
      end else begin
         // ack and rsp_valid are single-cycle pulses
         ack_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               unit_d_q <= 8'd0;
               if (w_win_vld) begin
                  id_q     <= w_win_id;
                  ack_q    <= 4'b0001 << w_win_id;
                  unit_d_q <= w_win_op;
                  to_cnt_q <= 8'd0;
                  state_q  <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               // A grant on the final allowed cycle still counts as success.
               if (unit_grant) begin
                  lat_cnt_q <= 4'd1;
                  state_q   <= S_WAIT;
               end else if (to_cnt_q == C_TO_LAST) begin
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= id_q;
                  rsp_data_q  <= 11'd0;
                  rsp_err_q   <= 1'b1;
                  unit_d_q    <= 8'd0;
                  state_q     <= S_RESP;
               end else begin
                  to_cnt_q <= to_cnt_q + 8'd1;
               end
            end
            S_WAIT: begin
               // unit_grant is deliberately ignored here.
               if (lat_cnt_q == C_LAT_LAST) begin
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= id_q;
                  rsp_data_q  <= unit_out;
                  rsp_err_q   <= 1'b0;
                  unit_d_q    <= 8'd0;
                  state_q     <= S_RESP;
               end else begin
                  lat_cnt_q <= lat_cnt_q + 4'd1;
               end
            end
            S_RESP: begin
               ptr_q    <= id_q + 2'd1;
               unit_d_q <= 8'd0;
               state_q  <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign unit_d    = unit_d_q;
   assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
